// File: rtl/stall_fwd_unit_pkg.sv
// rtl/stall_fwd_unit_pkg.sv - shared widths, encodings and hazard helpers
// Purpose: constants and pure functions used by the hazard controller.
//   REG_AW / T_W : register-number and Tuse/Tnew field widths.
//   FWD_*        : operand-mux select encodings.
//   T_*          : Tnew/Tuse constants from the decoder timing table.
package stall_fwd_unit_pkg;

  localparam int REG_AW = 5;
  localparam int T_W    = 3;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_E  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_W  = 2'd3;

  localparam logic [T_W-1:0] T_NONE = 3'd0;
  localparam logic [T_W-1:0] T_ALU  = 3'd1;
  localparam logic [T_W-1:0] T_LOAD = 3'd2;

  // Tnew counts down one per stage and parks at zero.
  function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] x);
    return (x == '0) ? '0 : x - T_W'(1);
  endfunction

  // Nearest-producer select. Only the nearest stage whose a3 matches is
  // considered; if its result is not ready yet the select stays at the
  // register source (the stall logic holds the consumer instead).
  function automatic logic [1:0] near_src(
    input logic             use_e,
    input logic [REG_AW-1:0] r,
    input logic [REG_AW-1:0] a_e,
    input logic [T_W-1:0]    t_e,
    input logic [REG_AW-1:0] a_m,
    input logic [T_W-1:0]    t_m,
    input logic [REG_AW-1:0] a_w,
    input logic [T_W-1:0]    t_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (r == '0)                 sel = FWD_RF;
    else if (use_e && a_e == r)  sel = (t_e == '0) ? FWD_E : FWD_RF;
    else if (a_m == r)           sel = (t_m == '0) ? FWD_M : FWD_RF;
    else if (a_w == r)           sel = (t_w == '0) ? FWD_W : FWD_RF;
    return sel;
  endfunction

  // Stall when the nearest in-flight producer (E before M) needs more
  // cycles than the consumer can wait. W results are always ready.
  function automatic logic src_stall(
    input logic             need,
    input logic [REG_AW-1:0] r,
    input logic [T_W-1:0]    tuse,
    input logic [REG_AW-1:0] a_e,
    input logic [T_W-1:0]    t_e,
    input logic [REG_AW-1:0] a_m,
    input logic [T_W-1:0]    t_m
  );
    logic st;
    st = 1'b0;
    if (!need || r == '0) st = 1'b0;
    else if (a_e == r)    st = (t_e > tuse);
    else if (a_m == r)    st = (t_m > tuse);
    return st;
  endfunction

endpackage

// File: rtl/stall_fwd_unit_hz_stage_entry.sv
// rtl/stall_fwd_unit_hz_stage_entry.sv - one pipeline-stage {a3, tnew} tracker
// Purpose: registered destination/Tnew pair for one of E, M, W.
// Ports: clk, reset_n (async low clear); clear loads a bubble; dec selects
//   whether the incoming tnew is decremented on load; a3_in/tnew_in next
//   value; a3/tnew current value.
module hz_stage_entry
  import stall_fwd_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              dec,
  input  logic [REG_AW-1:0] a3_in,
  input  logic [T_W-1:0]    tnew_in,
  output logic [REG_AW-1:0] a3,
  output logic [T_W-1:0]    tnew
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a3   <= '0;
      tnew <= '0;
    end else if (clear) begin
      a3   <= '0;
      tnew <= '0;
    end else begin
      a3   <= a3_in;
      tnew <= dec ? sat_dec(tnew_in) : tnew_in;
    end
  end

endmodule

// File: rtl/stall_fwd_unit.sv
// rtl/stall_fwd_unit.sv - MIPS 5-stage stall and forwarding controller
// Purpose: tracks {a3, tnew} for E/M/W, raises stall/bubble for the D
//   instruction and drives forwarding selects for D- and E-stage operands.
// Ports: clk, reset_n (async low); need_rs_d/need_rt_d, tuse_rs_d/tuse_rt_d,
//   tnew_d, rs_d, rt_d, a3_d from the D stage; stall, bubble_e,
//   fwd_rs_d/fwd_rt_d (0 RF,1 E,2 M,3 W), fwd_rs_e/fwd_rt_e (0 D/E,2 M,3 W).
// Option: STALL_PERF_CNT_EN adds stall_cycles[31:0], a wrapping count of
//   clock edges seen with stall high.
module stall_fwd_unit
  import stall_fwd_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              need_rs_d,
  input  logic              need_rt_d,
  input  logic [T_W-1:0]    tuse_rs_d,
  input  logic [T_W-1:0]    tuse_rt_d,
  input  logic [T_W-1:0]    tnew_d,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [REG_AW-1:0] a3_d,
  output logic              stall,
  output logic              bubble_e,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  logic [REG_AW-1:0] a3_e, a3_m, a3_w;
  logic [T_W-1:0]    tnew_e, tnew_m, tnew_w;
  logic [REG_AW-1:0] rs_e, rt_e;

  // E loads the D instruction as-is; a stall injects a bubble instead.
  hz_stage_entry u_ent_e (
    .clk(clk), .reset_n(reset_n), .clear(stall), .dec(1'b0),
    .a3_in(a3_d), .tnew_in(tnew_d), .a3(a3_e), .tnew(tnew_e)
  );

  hz_stage_entry u_ent_m (
    .clk(clk), .reset_n(reset_n), .clear(1'b0), .dec(1'b1),
    .a3_in(a3_e), .tnew_in(tnew_e), .a3(a3_m), .tnew(tnew_m)
  );

  hz_stage_entry u_ent_w (
    .clk(clk), .reset_n(reset_n), .clear(1'b0), .dec(1'b1),
    .a3_in(a3_m), .tnew_in(tnew_m), .a3(a3_w), .tnew(tnew_w)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rs_e <= '0;
      rt_e <= '0;
    end else if (stall) begin
      rs_e <= '0;
      rt_e <= '0;
    end else begin
      rs_e <= rs_d;
      rt_e <= rt_d;
    end
  end

  logic stall_rs, stall_rt;

  always_comb begin
    stall_rs = src_stall(need_rs_d, rs_d, tuse_rs_d, a3_e, tnew_e, a3_m, tnew_m);
    stall_rt = src_stall(need_rt_d, rt_d, tuse_rt_d, a3_e, tnew_e, a3_m, tnew_m);
    stall    = stall_rs | stall_rt;
    bubble_e = stall_rs | stall_rt;

    fwd_rs_d = near_src(1'b1, rs_d, a3_e, tnew_e, a3_m, tnew_m, a3_w, tnew_w);
    fwd_rt_d = near_src(1'b1, rt_d, a3_e, tnew_e, a3_m, tnew_m, a3_w, tnew_w);
    // The E operands only look downstream; E never forwards to itself.
    fwd_rs_e = near_src(1'b0, rs_e, a3_e, tnew_e, a3_m, tnew_m, a3_w, tnew_w);
    fwd_rt_e = near_src(1'b0, rt_e, a3_e, tnew_e, a3_m, tnew_m, a3_w, tnew_w);
  end

`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   stall_cycles <= '0;
    else if (stall) stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_stall_fwd_unit.sv
// tb/tb_stall_fwd_unit.sv - self-checking bench for stall_fwd_unit
module tb_stall_fwd_unit;
  import stall_fwd_unit_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic              need_rs_d, need_rt_d;
  logic [T_W-1:0]    tuse_rs_d, tuse_rt_d, tnew_d;
  logic [REG_AW-1:0] rs_d, rt_d, a3_d;
  logic              stall, bubble_e;
  logic [1:0]        fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
`ifdef STALL_PERF_CNT_EN
  logic [31:0]       stall_cycles;
`endif

  stall_fwd_unit dut (
    .clk(clk), .reset_n(reset_n),
    .need_rs_d(need_rs_d), .need_rt_d(need_rt_d),
    .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d), .tnew_d(tnew_d),
    .rs_d(rs_d), .rt_d(rt_d), .a3_d(a3_d),
    .stall(stall), .bubble_e(bubble_e),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e)
`ifdef STALL_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic              need_rs, need_rt;
    logic [T_W-1:0]    tuse_rs, tuse_rt, tnew;
    logic [REG_AW-1:0] rs, rt, a3;
    logic              st;
    logic [1:0]        frsd, frtd, frse, frte;
  } vec_t;

  function automatic vec_t mk(int nrs, int nrt, int urs, int urt, int tn,
                              int rs, int rt, int a3,
                              int st, int frsd, int frtd, int frse, int frte);
    vec_t v;
    v.need_rs = 1'(nrs); v.need_rt = 1'(nrt);
    v.tuse_rs = 3'(urs); v.tuse_rt = 3'(urt); v.tnew = 3'(tn);
    v.rs = 5'(rs); v.rt = 5'(rt); v.a3 = 5'(a3);
    v.st = 1'(st);
    v.frsd = 2'(frsd); v.frtd = 2'(frtd); v.frse = 2'(frse); v.frte = 2'(frte);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    need_rs_d = v.need_rs; need_rt_d = v.need_rt;
    tuse_rs_d = v.tuse_rs; tuse_rt_d = v.tuse_rt; tnew_d = v.tnew;
    rs_d = v.rs; rt_d = v.rt; a3_d = v.a3;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    chk({tag, " stall"}, stall, v.st);
    chk({tag, " bubble_e"}, bubble_e, v.st);
    chk({tag, " fwd_rs_d"}, fwd_rs_d, v.frsd);
    chk({tag, " fwd_rt_d"}, fwd_rt_d, v.frtd);
    chk({tag, " fwd_rs_e"}, fwd_rs_e, v.frse);
    chk({tag, " fwd_rt_e"}, fwd_rt_e, v.frte);
`ifdef STALL_PERF_CNT_EN
    chk({tag, " stall_cycles"}, stall_cycles, exp_cnt);
`endif
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(mk(0,0,0,0,0, 0,0,0, 0,0,0,0,0));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    exp_cnt = 0;
  endtask

  // Reference model: each in-flight instruction is a destination plus the
  // number of cycles still needed before its result exists. Index 0=E, 1=M, 2=W.
  int m_a3[3], m_rem[3];
  int m_rs_e, m_rt_e;

  function automatic int m_src(int r, int first);
    if (r == 0) return 0;
    for (int s = first; s < 3; s++)
      if (m_a3[s] == r) return (m_rem[s] == 0) ? s + 1 : 0;
    return 0;
  endfunction

  function automatic bit m_wait(bit need, int r, int tuse);
    if (!need || r == 0) return 0;
    for (int s = 0; s < 2; s++)
      if (m_a3[s] == r) return m_rem[s] > tuse;
    return 0;
  endfunction

  task automatic m_clear();
    for (int s = 0; s < 3; s++) begin m_a3[s] = 0; m_rem[s] = 0; end
    m_rs_e = 0; m_rt_e = 0;
  endtask

  task automatic m_advance(input vec_t v);
    for (int s = 2; s > 0; s--) begin
      m_a3[s]  = m_a3[s-1];
      m_rem[s] = (m_rem[s-1] > 0) ? m_rem[s-1] - 1 : 0;
    end
    if (v.st) begin
      m_a3[0] = 0; m_rem[0] = 0; m_rs_e = 0; m_rt_e = 0;
    end else begin
      m_a3[0] = int'(v.a3); m_rem[0] = int'(v.tnew);
      m_rs_e = int'(v.rs); m_rt_e = int'(v.rt);
    end
  endtask

  vec_t vecs[13];
  vec_t v;

  initial begin
    // lw $1 ; beq $1,$2 x3 ; addu $3 ; addu uses $3 ; jal ; jr $31 ;
    // lw $0 ; read $0 / $31 ; addu $4 ; sw $4 ; nop
    vecs[0]  = mk(1,0,1,0,2,  2,1,1,   0,0,0,0,0);
    vecs[1]  = mk(1,1,0,0,0,  1,2,0,   1,0,0,0,0);
    vecs[2]  = mk(1,1,0,0,0,  1,2,0,   1,0,0,0,0);
    vecs[3]  = mk(1,1,0,0,0,  1,2,0,   0,3,0,0,0);
    vecs[4]  = mk(1,1,1,1,1,  5,6,3,   0,0,0,0,0);
    vecs[5]  = mk(1,1,1,1,1,  3,0,7,   0,0,0,0,0);
    vecs[6]  = mk(0,0,0,0,0,  0,0,31,  0,0,0,2,0);
    vecs[7]  = mk(1,0,0,0,0,  31,0,0,  0,1,0,0,0);
    vecs[8]  = mk(1,0,1,0,2,  7,0,0,   0,3,0,2,0);
    vecs[9]  = mk(1,1,0,0,1,  0,31,4,  0,0,3,0,0);
    vecs[10] = mk(0,0,0,0,1,  4,0,4,   0,0,0,0,0);
    vecs[11] = mk(1,1,1,2,0,  0,4,0,   0,0,0,2,0);
    vecs[12] = mk(0,0,0,0,0,  0,0,0,   0,0,0,0,2);

    do_reset();
    @(negedge clk);
    check_all("reset", mk(0,0,0,0,0, 0,0,0, 0,0,0,0,0));
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check_all($sformatf("vec%0d", i), vecs[i]);
      @(posedge clk); #1;
      if (vecs[i].st) exp_cnt++;
    end

    // Reset asserted in the middle of a load-use stall.
    do_reset();
    drive(vecs[0]);
    @(posedge clk); #1;
    drive(vecs[1]);
    @(negedge clk);
    chk("midstall stall before reset", stall, 1'b1);
    #2 reset_n = 1'b0;
    exp_cnt = 0;
    #1;
    check_all("midstall reset", mk(1,1,0,0,0, 1,2,0, 0,0,0,0,0));
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check_all("after reset", mk(1,1,0,0,0, 1,2,0, 0,0,0,0,0));
    @(posedge clk); #1;

    // Randomized traffic on a small register set to force collisions.
    do_reset();
    m_clear();
    for (int n = 0; n < 400; n++) begin
      v.need_rs = 1'($urandom_range(0, 1));
      v.need_rt = 1'($urandom_range(0, 1));
      v.tuse_rs = 3'($urandom_range(0, 2));
      v.tuse_rt = 3'($urandom_range(0, 2));
      v.tnew    = 3'($urandom_range(0, 2));
      v.rs      = 5'($urandom_range(0, 3));
      v.rt      = 5'($urandom_range(0, 3));
      v.a3      = 5'($urandom_range(0, 3));
      v.st      = m_wait(v.need_rs, int'(v.rs), int'(v.tuse_rs)) |
                  m_wait(v.need_rt, int'(v.rt), int'(v.tuse_rt));
      v.frsd    = 2'(m_src(int'(v.rs), 0));
      v.frtd    = 2'(m_src(int'(v.rt), 0));
      v.frse    = 2'(m_src(m_rs_e, 1));
      v.frte    = 2'(m_src(m_rt_e, 1));
      drive(v);
      @(negedge clk);
      check_all($sformatf("rnd%0d", n), v);
      @(posedge clk); #1;
      if (v.st) exp_cnt++;
      m_advance(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stall_fwd_unit.md
Name: stall_fwd_unit

Overview:
- Pipeline hazard controller for the 5-stage MIPS core.
- Consumes the D-stage Tuse/Tnew/need signals and register numbers, and tracks destination register and remaining Tnew for the instructions in E, M and W.
- Produces the F/D stall and E bubble, plus forwarding selects for the D-stage and E-stage operand muxes.
- Sits between the D-stage decoder/timing logic and the datapath pipeline registers.

Parameters:
- REG_AW, 5, register-number width.
- T_W, 3, width of Tuse/Tnew fields; matches the decoder's 3-bit encoding.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- need_rs_d  in  1  D instruction reads rs.
- need_rt_d  in  1  D instruction reads rt.
- tuse_rs_d  in  T_W  cycles until rs is consumed (0 = D, 1 = E, 2 = M).
- tuse_rt_d  in  T_W  same for rt.
- tnew_d  in  T_W  cycles after entering E until the result exists (lw 2, ALU 1, link/none 0).
- rs_d  in  REG_AW  D-stage rs number.
- rt_d  in  REG_AW  D-stage rt number.
- a3_d  in  REG_AW  D-stage write register; 0 = no write.
- stall  out  1  freeze PC and F/D register.
- bubble_e  out  1  clear D/E register this cycle; equals stall.
- fwd_rs_d  out  2  D rs source: 0 RF, 1 E, 2 M, 3 W.
- fwd_rt_d  out  2  D rt source, same encoding.
- fwd_rs_e  out  2  E rs source: 0 D/E register, 2 M, 3 W.
- fwd_rt_e  out  2  E rt source, same encoding.

Behaviour:
- State: three entries E, M, W, each holding {a3, tnew}. E additionally holds rs_e, rt_e.
- Reset (async, reset_n low): all a3, tnew, rs_e, rt_e cleared to 0. Outputs are combinational from state, so at reset they are stall=0, bubble_e=0, all fwd=0.
- Each clk edge:
  - W ← {M.a3, sat_dec(M.tnew)}; M ← {E.a3, sat_dec(E.tnew)}.
  - sat_dec(x) = (x==0) ? 0 : x-1.
  - If stall=0: E ← {a3_d, tnew_d, rs_d, rt_d}. If stall=1: E ← all zero (bubble).
- Stall (combinational):
  - stall_rs = need_rs_d & rs_d!=0 & OR over S in {E,M} of (S.a3==rs_d & S.tnew > tuse_rs_d).
  - stall_rt is analogous. stall = stall_rs | stall_rt.
  - W never causes a stall; its tnew is always 0 for legal encodings.
- D forwarding:
  - Nearest-stage priority E > M > W. A stage matches when a3==reg, reg!=0, and tnew==0.
  - If the nearest stage whose a3 matches has tnew != 0, the select is 0 (stall covers it). No fall-through to an older stage.
- E forwarding:
  - Match rs_e/rt_e against M then W, using the same nearest-match rule.
  - The M match uses the M tnew after decrement semantics, i.e. the stored M.tnew==0.
- Register 0: never matched; never forwarded; never stalls.
- Simultaneous E and M match on the same reg: E wins for both stall and forward.
- Stall persists cycle by cycle until the condition clears. Maximum 2 consecutive stall cycles for legal inputs (lw → beq).
- Reset mid-stall: stall drops immediately; the pipeline resumes with empty E/M/W.

Optional Feature:
- Macro STALL_PERF_CNT_EN.
- Defined:
  - Adds output port stall_cycles [31:0].
  - Counts clk edges with stall=1; reset to 0 by reset_n.
  - Wraps modulo 2^32.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package/header holds:
  - fwd select encodings FWD_RF=0, FWD_E=1, FWD_M=2, FWD_W=3;
  - T_W and REG_AW;
  - Tnew/Tuse constants (T_ALU=1, T_LOAD=2, T_NONE=0).
- One sub-module, hz_stage_entry: the registered {a3, tnew} entry with saturating decrement, bubble/load control and async clear, instantiated three times.

Test Plan:
- lw $1 enters E (tnew_d=2); next D is beq $1,$2 (tuse_rs=0) → stall=1 for 2 cycles, then fwd_rs_d=3 on the third cycle.
- addu $3 in E (tnew 1); D is addu using $3 (tuse 1) → stall=0, fwd_rs_d=0; next cycle fwd_rs_e=2.
- jal (a3=31, tnew 0) in E; D is jr $31 → stall=0, fwd_rs_d=1.
- a3=0 write in E with tnew 2; D reads $0 with need_rs=1 → stall=0, fwd_rs_d=0.
- E and M both write $4, E tnew=1, D sw reads $4 as rt with tuse_rt=2 → stall=0, fwd_rt_d=0; next cycle fwd_rt_e=2.
- Assert reset_n low during a lw stall → stall=0 immediately; all fwd=0; with STALL_PERF_CNT_EN, stall_cycles=0.
